// File: rtl/alu_issue.sv
// alu_issue: decodes ALUOp/funct3/funct7b5 into ALU control, selects operand B, presents A/B/ALUControl downstream.
// Latency: 1 cycle from input accept to out_valid when the output register is empty or draining.
// Backpressure: valid/ready, with the output register plus one skid entry; in_ready is a pure register (!skid full).
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            alu_src,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALUControl,
  output logic            illegal
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_XOR = 4'b1000;
  localparam logic [3:0] CTL_SLL = 4'b1001;

  // One buffered operation; illegal travels with its operands.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctl;
    logic            ill;
  } entry_t;

  entry_t in_ent;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_vld_q, out_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   in_rdy_q, in_rdy_d;
  logic   accept;
  logic   out_free;

  // Decode the incoming instruction fields into an entry
  always_comb begin
    in_ent.a   = rs1_val;
    in_ent.b   = alu_src ? imm : rs2_val;
    in_ent.ctl = CTL_ADD;
    in_ent.ill = 1'b0;
    case (alu_op)
      2'b00: in_ent.ctl = CTL_ADD;
      2'b01: in_ent.ctl = CTL_SUB;
      default: begin
        case (funct3)
          // Only R-type honours funct7b5; ADDI with bit 30 set is still ADD.
          3'b000:  in_ent.ctl = (alu_op == 2'b10 && funct7b5) ? CTL_SUB : CTL_ADD;
          3'b001:  in_ent.ctl = CTL_SLL;
          3'b010:  in_ent.ctl = CTL_SLT;
          3'b100:  in_ent.ctl = CTL_XOR;
          3'b110:  in_ent.ctl = CTL_OR;
          3'b111:  in_ent.ctl = CTL_AND;
          default: begin
            in_ent.ctl = CTL_ADD;
            in_ent.ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign accept   = in_valid & in_rdy_q;
  assign out_free = ~out_vld_q | out_ready;

  // Next state of the output register and skid entry; flush wins over every handshake
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      // A full skid entry implies in_ready is low, so no accept can collide with it.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = in_ent;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = ~skid_vld_d;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready   = in_rdy_q;
  assign out_valid  = out_vld_q;
  assign A          = out_q.a;
  assign B          = out_q.b;
  assign ALUControl = out_q.ctl;
  assign illegal    = out_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode table, operand select, skid-buffer backpressure, flush, async reset.
// Inputs change on the falling edge; outputs are compared on the falling edge after the capturing rising edge.
// Observed outputs are packed as {out_valid, A, B, ALUControl, illegal} for whole-state comparisons.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        alu_src;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic        illegal;

  logic [69:0] obs;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  // Decode sweep vectors: alu_op, funct3, expected control, expected illegal
  logic [1:0] sw_op  [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10};
  logic [2:0] sw_f3  [10] = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b111, 3'b011, 3'b101, 3'b111, 3'b011, 3'b000};
  logic [3:0] sw_ctl [10] = '{4'b1001, 4'b0111, 4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0010};
  logic       sw_ill [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  alu_issue #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_src    (alu_src),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, A, B, ALUControl, illegal};

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic src, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    in_valid = v;
    alu_op   = op;
    funct3   = f3;
    funct7b5 = f7;
    alu_src  = src;
    rs1_val  = r1;
    rs2_val  = r2;
    imm      = im;
  endtask

  task automatic test_reset();
    vec_cnt++;
    if (obs !== 70'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_rtype_sub();
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 32'h0000_0055);
    @(negedge clk);
    vec_cnt++;
    if (obs !== {1'b1, 32'd10, 32'd3, 4'b0110, 1'b0}) begin
      err_cnt++;
      $display("FAIL rtype_sub: got %h want %h", obs, {1'b1, 32'd10, 32'd3, 4'b0110, 1'b0});
    end
    in_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_idle: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_addi();
    drive(1'b1, 2'b11, 3'b000, 1'b1, 1'b1, 32'd7, 32'd5, 32'hFFFF_FFFC);
    @(negedge clk);
    vec_cnt++;
    if (obs !== {1'b1, 32'd7, 32'hFFFF_FFFC, 4'b0010, 1'b0}) begin
      err_cnt++;
      $display("FAIL addi_f7: got %h want %h", obs, {1'b1, 32'd7, 32'hFFFF_FFFC, 4'b0010, 1'b0});
    end
    in_valid = 1'b0;
  endtask

  // Back-to-back sweep: one new op per cycle with out_ready held high
  task automatic test_decode_sweep();
    out_ready = 1'b1;
    drive(1'b1, sw_op[0], sw_f3[0], 1'b1, 1'b0, 32'd0, 32'd100, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== {1'b1, 32'(i), 32'(100 + i), sw_ctl[i], sw_ill[i]}) begin
        err_cnt++;
        $display("FAIL sweep_%0d: got %h want %h", i, obs, {1'b1, 32'(i), 32'(100 + i), sw_ctl[i], sw_ill[i]});
      end
      if (i < 9) drive(1'b1, sw_op[i+1], sw_f3[i+1], (i + 1 != 9), 1'b0, 32'(i + 1), 32'(101 + i), 32'd0);
      else in_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0);   // X: XOR
    @(negedge clk);
    vec_cnt++;
    if ({obs, in_ready} !== {1'b1, 32'd1, 32'd2, 4'b1000, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL bp_x_out: got %h want %h", {obs, in_ready}, {1'b1, 32'd1, 32'd2, 4'b1000, 1'b0, 1'b1});
    end
    drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0);   // Y: OR
    @(negedge clk);
    vec_cnt++;
    if ({obs, in_ready} !== {1'b1, 32'd1, 32'd2, 4'b1000, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL bp_y_skid: got %h want %h", {obs, in_ready}, {1'b1, 32'd1, 32'd2, 4'b1000, 1'b0, 1'b0});
    end
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0);   // Z: SUB
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vec_cnt++;
      if ({obs, in_ready} !== {1'b1, 32'd1, 32'd2, 4'b1000, 1'b0, 1'b0}) begin
        err_cnt++;
        $display("FAIL bp_stall_%0d: got %h want %h", k, {obs, in_ready}, {1'b1, 32'd1, 32'd2, 4'b1000, 1'b0, 1'b0});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({obs, in_ready} !== {1'b1, 32'd3, 32'd4, 4'b0001, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL bp_y_out: got %h want %h", {obs, in_ready}, {1'b1, 32'd3, 32'd4, 4'b0001, 1'b0, 1'b1});
    end
    @(negedge clk);
    vec_cnt++;
    if (obs !== {1'b1, 32'd5, 32'd6, 4'b0110, 1'b0}) begin
      err_cnt++;
      $display("FAIL bp_z_out: got %h want %h", obs, {1'b1, 32'd5, 32'd6, 4'b0110, 1'b0});
    end
    in_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_drained: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 32'd11, 32'd12, 32'd0);
    @(negedge clk);
    drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 32'd13, 32'd14, 32'd0);
    @(negedge clk);
    vec_cnt++;
    if (in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_full: in_ready got %b want 0", in_ready);
    end
    flush = 1'b1;
    drive(1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 32'd15, 32'd16, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      err_cnt++;
      $display("FAIL flush_empty: {out_valid,in_ready} got %b want 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 32'd21, 32'd22, 32'd23);
    @(negedge clk);
    vec_cnt++;
    if (obs !== {1'b1, 32'd21, 32'd23, 4'b0010, 1'b0}) begin
      err_cnt++;
      $display("FAIL flush_next_op: got %h want %h", obs, {1'b1, 32'd21, 32'd23, 4'b0010, 1'b0});
    end
    // Flush while in_ready is high: the op offered in the flush cycle must vanish
    flush = 1'b1;
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'd31, 32'd32, 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      err_cnt++;
      $display("FAIL flush_discard: {out_valid,in_ready} got %b want 01", {out_valid, in_ready});
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_no_ghost: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 32'd41, 32'd42, 32'd0);
    @(negedge clk);
    drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 32'd43, 32'd44, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b10) begin
      err_cnt++;
      $display("FAIL areset_setup: {out_valid,in_ready} got %b want 10", {out_valid, in_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({obs, in_ready} !== {70'd0, 1'b1}) begin
      err_cnt++;
      $display("FAIL areset_immediate: got %h want %h", {obs, in_ready}, {70'd0, 1'b1});
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      err_cnt++;
      $display("FAIL areset_after: {out_valid,in_ready} got %b want 01", {out_valid, in_ready});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_rtype_sub();
    test_addi();
    test_decode_sweep();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
